usb_tx_seq_up: RTL and testbench

Upstream SIE transmit sequencer. Serialises one USB packet per `start` request: SYNC, PID, optional payload, CRC5/CRC16, then EOP. The bit-stuff counter supplies `stuff_zero`; this block supplies its `serial_out`, `setup_done` and `pkt_done`, and inserts each stuffed zero. Output `serial_out` is the raw pre-NRZI bit stream, one bit per `clk`, LSB first; NRZI/line driving is downstream.

---
 rtl/usb_tx_seq_up_pkg.sv | 33 +++
 rtl/usb_tx_seq_up_if.sv | 28 ++
 rtl/usb_tx_seq_up_crc.sv | 41 ++++
 rtl/usb_tx_seq_up.sv | 180 ++++++++++++++++++
 tb/tb_usb_tx_seq_up.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_tx_seq_up_pkg.sv
// Shared types and constants for the upstream USB transmit sequencer.
// BITSTUFF_LEN is shared with the external bit-stuff counter.
package usb_up_pkg;
    localparam int BITSTUFF_LEN = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_PAYLOAD,
        ST_CRC,
        ST_EOP
    } state_e;

    typedef enum logic [1:0] {
        KIND_HS    = 2'd0,
        KIND_TOKEN = 2'd1,
        KIND_DATA  = 2'd2,
        KIND_RSVD  = 2'd3
    } kind_e;

    localparam logic [7:0]  SYNC_PATTERN = 8'b1000_0000;
    localparam logic [4:0]  CRC5_POLY    = 5'h05;
    localparam logic [4:0]  CRC5_INIT    = 5'h1F;
    localparam logic [15:0] CRC16_POLY   = 16'h8005;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

    // Last bit index of each field, so the bit counter can compare directly.
    localparam logic [3:0] BYTE_LAST  = 4'd7;
    localparam logic [3:0] TOKEN_LAST = 4'd10;
    localparam logic [3:0] CRC5_LAST  = 4'd4;
    localparam logic [3:0] CRC16_LAST = 4'd15;
endpackage

// File: rtl/usb_tx_seq_up_if.sv
// Packet request, payload handshake and serial output bundle of the sequencer.
interface usb_tx_seq_up_if;
    logic        start;
    logic [1:0]  pkt_kind;
    logic [3:0]  pid;
    logic [10:0] tok_bits;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic        stuff_zero;
    logic        serial_out;
    logic        setup_done;
    logic        pkt_done;
    logic        se0;
    logic        busy;
    logic        underrun;

    modport slave (
        input  start, pkt_kind, pid, tok_bits, tx_data, tx_valid, tx_last, stuff_zero,
        output tx_ready, serial_out, setup_done, pkt_done, se0, busy, underrun
    );

    modport master (
        output start, pkt_kind, pid, tok_bits, tx_data, tx_valid, tx_last, stuff_zero,
        input  tx_ready, serial_out, setup_done, pkt_done, se0, busy, underrun
    );
endinterface

// File: rtl/usb_tx_seq_up_crc.sv
// Serial CRC5/CRC16 generator, MSB-first register, fed one payload bit per enable.
// crc_out presents the complemented remainder ready for transmission.
module usb_crc_up
    import usb_up_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        en,
    input  logic        sel,
    input  logic        bit_in,
    output logic [15:0] crc_out
);
    logic [15:0] crc_q, crc_d;
    logic        fb16, fb5;

    always_comb begin
        fb16  = bit_in ^ crc_q[15];
        fb5   = bit_in ^ crc_q[4];
        crc_d = crc_q;
        if (clr) begin
            crc_d = sel ? CRC16_INIT : {11'b0, CRC5_INIT};
        end else if (en) begin
            if (sel) begin
                crc_d = {crc_q[14:0], 1'b0} ^ (fb16 ? CRC16_POLY : 16'h0000);
            end else begin
                crc_d = {11'b0, crc_q[3:0], 1'b0} ^ {11'b0, (fb5 ? CRC5_POLY : 5'h00)};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = sel ? ~crc_q : {11'b0, ~crc_q[4:0]};
endmodule

// File: rtl/usb_tx_seq_up.sv
// Upstream SIE transmit sequencer: SYNC, PID, payload, CRC and EOP as a raw
// LSB-first bit stream, holding its position whenever a stuffed zero is requested.
module usb_tx_seq_up
    import usb_up_pkg::*;
#(
    parameter int EOP_SE0_CYC = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    usb_tx_seq_up_if.slave  bus
);
    localparam logic [3:0] SE0_LAST = 4'(EOP_SE0_CYC);

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [10:0] shift_q, shift_d;
    logic [10:0] tok_q, tok_d;
    logic        last_q, last_d;

    logic        serial_c, se0_c, setup_c, done_c, ready_c, underrun_c;
    logic        crc_en, crc_sel, crc_clr;
    logic [15:0] crc_out;
    logic [3:0]  crc_last, crc_idx;

    assign crc_sel  = (kind_q == KIND_DATA);
    assign crc_clr  = (state_q == ST_SYNC);
    assign crc_last = crc_sel ? CRC16_LAST : CRC5_LAST;
    assign crc_idx  = crc_last - cnt_q;

    usb_crc_up u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (crc_clr),
        .en      (crc_en),
        .sel     (crc_sel),
        .bit_in  (shift_q[0]),
        .crc_out (crc_out)
    );

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tok_d      = tok_q;
        last_d     = last_q;
        serial_c   = 1'b0;
        se0_c      = 1'b0;
        setup_c    = 1'b0;
        done_c     = 1'b0;
        ready_c    = 1'b0;
        underrun_c = 1'b0;
        crc_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SYNC;
                    cnt_d   = 4'd0;
                    kind_d  = kind_e'(bus.pkt_kind);
                    tok_d   = bus.tok_bits;
                    shift_d = {3'b000, ~bus.pid, bus.pid};
                end
            end
            ST_SYNC: begin
                serial_c = SYNC_PATTERN[cnt_q[2:0]];
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == BYTE_LAST) begin
                    setup_c = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = ST_PID;
                end
            end
            ST_PID: begin
                if (!bus.stuff_zero) begin
                    serial_c = shift_q[0];
                    shift_d  = {1'b0, shift_q[10:1]};
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q == BYTE_LAST) begin
                        cnt_d = 4'd0;
                        case (kind_q)
                            KIND_TOKEN: begin
                                shift_d = tok_q;
                                state_d = ST_PAYLOAD;
                            end
                            KIND_DATA: begin
                                if (bus.tx_valid) begin
                                    shift_d = {3'b000, bus.tx_data};
                                    last_d  = bus.tx_last;
                                    ready_c = 1'b1;
                                    state_d = ST_PAYLOAD;
                                end else begin
                                    state_d = ST_CRC;
                                end
                            end
                            default: state_d = ST_EOP;
                        endcase
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!bus.stuff_zero) begin
                    serial_c = shift_q[0];
                    crc_en   = 1'b1;
                    shift_d  = {1'b0, shift_q[10:1]};
                    cnt_d    = cnt_q + 4'd1;
                    if (kind_q == KIND_TOKEN) begin
                        if (cnt_q == TOKEN_LAST) begin
                            cnt_d   = 4'd0;
                            state_d = ST_CRC;
                        end
                    end else if (cnt_q == BYTE_LAST) begin
                        cnt_d = 4'd0;
                        if (last_q) begin
                            state_d = ST_CRC;
                        end else if (bus.tx_valid) begin
                            shift_d = {3'b000, bus.tx_data};
                            last_d  = bus.tx_last;
                            ready_c = 1'b1;
                        end else begin
                            // Missing byte: abort straight to EOP without CRC.
                            underrun_c = 1'b1;
                            state_d    = ST_EOP;
                        end
                    end
                end
            end
            ST_CRC: begin
                if (!bus.stuff_zero) begin
                    serial_c = crc_out[crc_idx];
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q == crc_last) begin
                        cnt_d   = 4'd0;
                        state_d = ST_EOP;
                    end
                end
            end
            ST_EOP: begin
                if (cnt_q == 4'd0 && bus.stuff_zero) begin
                    serial_c = 1'b0;
                end else if (cnt_q < SE0_LAST) begin
                    se0_c = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    done_c  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_HS;
            cnt_q   <= '0;
            shift_q <= '0;
            tok_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            tok_q   <= tok_d;
            last_q  <= last_d;
        end
    end

    assign bus.serial_out = serial_c;
    assign bus.se0        = se0_c;
    assign bus.setup_done = setup_c;
    assign bus.pkt_done   = done_c;
    assign bus.tx_ready   = ready_c;
    assign bus.underrun   = underrun_c;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_usb_tx_seq_up.sv
// Scoreboard bench for usb_tx_seq_up: a packet-level reference model queues the
// expected per-cycle line symbols; a monitor compares them while the DUT is busy.
module tb_usb_tx_seq_up;
    import usb_up_pkg::*;

    localparam int EOP_SE0_CYC = 2;
    localparam int MAX_CYC     = 400;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    usb_tx_seq_up_if bus ();

    usb_tx_seq_up #(.EOP_SE0_CYC(EOP_SE0_CYC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Entry layout: {serial_out, se0, setup_done, pkt_done, tx_ready, underrun}
    logic [5:0] exp_q[$];
    logic [7:0] pay[16];
    int         pay_n;
    int         pay_avail;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         pkt_no   = 0;

    // Reflected (LSB-first) CRC forms, independent of the shift-register form.
    function automatic logic [4:0] crc5_ref(input logic [10:0] d);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 5'h14;
            else             c = c >> 1;
        end
        return ~c;
    endfunction

    function automatic logic [15:0] crc16_ref(input int cnt);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int j = 0; j < cnt; j++) begin
            c = c ^ {8'h00, pay[j]};
            for (int k = 0; k < 8; k++) begin
                if (c[0]) c = (c >> 1) ^ 16'hA001;
                else      c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic build_expected(input logic [1:0] kind, input logic [3:0] pid,
                                  input logic [10:0] tok, input int n, input int avail);
        logic [5:0]  raw[$];
        logic [7:0]  pb;
        logic [7:0]  b;
        logic [4:0]  c5;
        logic [15:0] c16;
        logic        r, u;
        int          ones;
        for (int i = 0; i < 8; i++) raw.push_back({(i == 7), 1'b0, (i == 7), 3'b000});
        pb = {~pid, pid};
        for (int i = 0; i < 8; i++) begin
            r = (i == 7) && (kind == 2'd2) && (avail > 0);
            raw.push_back({pb[i], 3'b000, r, 1'b0});
        end
        if (kind == 2'd1) begin
            for (int i = 0; i < 11; i++) raw.push_back({tok[i], 5'b00000});
            c5 = crc5_ref(tok);
            for (int i = 0; i < 5; i++) raw.push_back({c5[i], 5'b00000});
        end else if (kind == 2'd2) begin
            for (int j = 0; j < avail; j++) begin
                b = pay[j];
                for (int i = 0; i < 8; i++) begin
                    r = (i == 7) && (j < avail - 1);
                    u = (i == 7) && (j == avail - 1) && (avail < n);
                    raw.push_back({b[i], 3'b000, r, u});
                end
            end
            if (avail == n || avail == 0) begin
                c16 = crc16_ref(avail);
                for (int i = 0; i < 16; i++) raw.push_back({c16[i], 5'b00000});
            end
        end
        ones = 0;
        foreach (raw[k]) begin
            exp_q.push_back(raw[k]);
            if (raw[k][5]) ones++;
            else           ones = 0;
            if (ones == BITSTUFF_LEN) begin
                exp_q.push_back(6'b000000);
                ones = 0;
            end
        end
        for (int i = 0; i < EOP_SE0_CYC; i++) exp_q.push_back(6'b010000);
        exp_q.push_back(6'b000100);
    endtask

    // Bit-stuff counter model: requests a zero after BITSTUFF_LEN consecutive ones.
    initial begin
        int   ones;
        logic so_s, se_s;
        ones = 0;
        bus.stuff_zero = 1'b0;
        forever begin
            @(negedge clk);
            so_s = bus.serial_out;
            se_s = bus.se0;
            @(posedge clk);
            #1;
            if (!reset_n)             ones = 0;
            else if (so_s && !se_s)   ones++;
            else                      ones = 0;
            bus.stuff_zero = (ones == BITSTUFF_LEN);
        end
    end

    // Payload source: presents pay[idx] and advances on each tx_ready.
    initial begin
        int   idx;
        logic rdy_s, st_s;
        idx = 0;
        forever begin
            bus.tx_valid = (idx < pay_avail);
            bus.tx_data  = (idx < 16) ? pay[idx] : 8'($urandom);
            bus.tx_last  = (idx == pay_n - 1);
            @(negedge clk);
            rdy_s = bus.tx_ready;
            st_s  = bus.start && !bus.busy;
            @(posedge clk);
            #1;
            if (st_s)       idx = 0;
            else if (rdy_s) idx++;
        end
    end

    // Monitor: one expected entry per busy cycle.
    initial begin
        logic [5:0] got, e;
        int         cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (reset_n && bus.busy) begin
                got = {bus.serial_out, bus.se0, bus.setup_done, bus.pkt_done,
                       bus.tx_ready, bus.underrun};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_busy_cycle pkt=%0d got=%b required=idle", pkt_no, got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL line_symbol pkt=%0d cyc=%0d got=%b required=%b (so,se0,setup,done,rdy,und)",
                                 pkt_no, cyc, got, e);
                    end
                end
                cyc++;
            end else begin
                cyc = 0;
            end
        end
    end

    task automatic check_quiet(input string name);
        logic [6:0] v;
        v = {bus.serial_out, bus.se0, bus.setup_done, bus.pkt_done,
             bus.tx_ready, bus.underrun, bus.busy};
        n_checks++;
        if (v !== 7'b0) begin
            n_fail++;
            $display("FAIL %s got=%b required=0000000", name, v);
        end
    endtask

    task automatic launch(input logic [1:0] kind, input logic [3:0] pid,
                          input logic [10:0] tok, input int n, input int avail);
        pay_n     = n;
        pay_avail = avail;
        build_expected(kind, pid, tok, n, avail);
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.pkt_kind = kind;
        bus.pid      = pid;
        bus.tok_bits = tok;
        @(posedge clk);
        #1;
    endtask

    task automatic run_pkt(input logic [1:0] kind, input logic [3:0] pid,
                           input logic [10:0] tok, input int n, input int avail);
        int cyc;
        pkt_no++;
        launch(kind, pid, tok, n, avail);
        cyc = 0;
        // Keep disturbing start and the packet fields while the packet is in flight.
        while (exp_q.size() > 0 && cyc < MAX_CYC) begin
            bus.start    = ($urandom % 6 == 0);
            bus.pid      = 4'($urandom);
            bus.pkt_kind = 2'($urandom);
            bus.tok_bits = 11'($urandom);
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        n_checks++;
        if (cyc >= MAX_CYC) begin
            n_fail++;
            $display("FAIL pkt_timeout pkt=%0d got=%0d_left required=0_left", pkt_no, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check_quiet("idle_after_pkt");
        $display("pkt %0d kind=%0d pid=%h tok=%h bytes=%0d avail=%0d cycles=%0d",
                 pkt_no, kind, pid, tok, n, avail, cyc);
    endtask

    initial begin
        int         n, avail;
        logic [1:0] kind;
        bus.start    = 1'b0;
        bus.pkt_kind = 2'd0;
        bus.pid      = 4'd0;
        bus.tok_bits = 11'd0;
        pay_n        = 0;
        pay_avail    = 0;
        for (int i = 0; i < 16; i++) pay[i] = 8'h00;

        #2;
        check_quiet("reset_state");
        #21;
        reset_n = 1'b1;

        run_pkt(2'd0, 4'b0010, 11'd0, 0, 0);            // ACK
        run_pkt(2'd1, 4'hD, 11'd0, 0, 0);               // SETUP addr 0 endp 0
        run_pkt(2'd2, 4'h3, 11'd0, 0, 0);               // DATA0 zero length
        pay[0] = 8'hFF;
        run_pkt(2'd2, 4'h3, 11'd0, 1, 1);               // DATA0 0xFF, stuffed
        pay[0] = 8'h5A; pay[1] = 8'h11; pay[2] = 8'h22;
        run_pkt(2'd2, 4'hB, 11'd0, 3, 1);               // underrun at 2nd byte
        run_pkt(2'd3, 4'h6, 11'h7FF, 0, 0);             // reserved kind = handshake

        for (int p = 0; p < 30; p++) begin
            kind = 2'($urandom_range(0, 3));
            n = 0;
            avail = 0;
            if (kind == 2'd2) begin
                n = $urandom_range(0, 4);
                avail = (n > 1 && $urandom % 4 == 0) ? $urandom_range(1, n - 1) : n;
                for (int i = 0; i < n; i++)
                    pay[i] = ($urandom % 3 == 0) ? 8'hFF : 8'($urandom);
            end
            run_pkt(kind, 4'($urandom), ($urandom % 3 == 0) ? 11'h7FF : 11'($urandom), n, avail);
        end

        // Asynchronous reset in the middle of a data payload.
        pkt_no++;
        for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
        launch(2'd2, 4'h3, 11'd0, 4, 4);
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_quiet("async_reset_outputs");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(negedge clk);
        check_quiet("idle_after_reset");
        $display("pkt %0d aborted by reset mid-payload", pkt_no);

        run_pkt(2'd0, 4'b1010, 11'd0, 0, 0);
        pay[0] = 8'hFF; pay[1] = 8'hFF;
        run_pkt(2'd2, 4'hB, 11'd0, 2, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
